deck_scheduler: RTL and testbench

- Sequencing controller for the UNO card deck block. It sits between the game logic and the deck.
- At game start it triggers the shuffle and deals the opening hands. It then flips the first discard card.
- During play it arbitrates draw requests from NUM_PLAYERS players (round-robin) and discard-recycle insert requests (fixed priority), one transaction at a time.
- It drives the deck's start/insert/draw/prev_card inputs and consumes its done/drawn/card outputs.

---
 rtl/deck_scheduler_pkg.sv | 60 ++++++
 rtl/deck_scheduler_rr_arbiter.sv | 48 ++++
 rtl/deck_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_deck_scheduler.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deck_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deck_pkg
//  Description : Shared types and constants for the UNO deck scheduler.
//                Holds the card layout, colour/value codes, the one-hot
//                draw codes understood by the deck, the scheduler state
//                encoding and the count-code decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package deck_pkg;

    // Card layout as carried on every 6-bit card bus: {color, value}
    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_YELLOW = 2'd1;
    localparam logic [1:0] COLOR_GREEN  = 2'd2;
    localparam logic [1:0] COLOR_BLUE   = 2'd3;

    localparam logic [3:0] VALUE_SKIP    = 4'd10;
    localparam logic [3:0] VALUE_REVERSE = 4'd11;
    localparam logic [3:0] VALUE_DRAW2   = 4'd12;
    localparam logic [3:0] VALUE_WILD    = 4'd13;
    localparam logic [3:0] VALUE_WILD4   = 4'd14;

    // One-hot draw codes; the code value equals the number of cards
    localparam logic [2:0] DRAW_NONE = 3'b000;
    localparam logic [2:0] DRAW_1    = 3'b001;
    localparam logic [2:0] DRAW_2    = 3'b010;
    localparam logic [2:0] DRAW_4    = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SHUFFLE   = 4'd1,
        S_DEAL_REQ  = 4'd2,
        S_DEAL_WAIT = 4'd3,
        S_FLIP      = 4'd4,
        S_FLIP_WAIT = 4'd5,
        S_READY     = 4'd6,
        S_DRAW_REQ  = 4'd7,
        S_DRAW_WAIT = 4'd8,
        S_INSERT    = 4'd9
    } sched_state_t;

    // Player count code -> deck draw code. The reserved code 3 draws one card.
    function automatic logic [2:0] cnt_to_onehot(input logic [1:0] code);
        logic [2:0] v;
        case (code)
            2'd1:    v = DRAW_2;
            2'd2:    v = DRAW_4;
            default: v = DRAW_1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/deck_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the first requester
//                at or after i_ptr, wrapping past NUM_PLAYERS-1 to 0.
//  Ports       : i_req   - request vector, one bit per player
//                i_ptr   - index with highest priority this cycle
//                o_grant - granted player index (0 when nothing requested)
//                o_valid - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PLAYERS = 4,
    parameter int PID_W       = $clog2(NUM_PLAYERS)
) (
    input  logic [NUM_PLAYERS-1:0] i_req,
    input  logic [PID_W-1:0]       i_ptr,
    output logic [PID_W-1:0]       o_grant,
    output logic                   o_valid
);

    logic [PID_W:0]   w_sum;
    logic [PID_W-1:0] w_grant;
    logic             w_valid;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester (smallest offset from the pointer) is the last to win.
    always_comb begin
        w_grant = '0;
        w_valid = 1'b0;
        w_sum   = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            w_sum = {1'b0, i_ptr} + (PID_W+1)'(i);
            if (w_sum >= (PID_W+1)'(NUM_PLAYERS)) begin
                w_sum = w_sum - (PID_W+1)'(NUM_PLAYERS);
            end
            if (i_req[w_sum[PID_W-1:0]]) begin
                w_grant = w_sum[PID_W-1:0];
                w_valid = 1'b1;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_valid = w_valid;

endmodule
`default_nettype wire

// File: rtl/deck_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : deck_scheduler
//  Description : Sequencing controller between UNO game logic and the deck.
//                Shuffles and deals opening hands, flips the first discard,
//                then serves player draws (round-robin) and recycle inserts
//                (priority over draws), one transaction at a time.
//  Ports       : i_clk/i_rst        - clock, synchronous active-high reset
//                i_game_start        - start shuffle + deal (idle only)
//                i_draw_req/cnt      - per-player draw request and count code
//                i_insert_req/card   - recycle request and card
//                o_deck_*            - strobes / card presented to the deck
//                i_deck_done/drawn/card - deck status and drawn cards
//                o_card_valid/card/pid - card delivery to a player
//                o_top_valid         - opening discard card on o_card
//                o_draw_ack/insert_ack - transaction complete pulses
//                o_ready             - waiting for requests
//  Revision    : 1.0 - initial release
// ============================================================================
module deck_scheduler
    import deck_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int HAND_SIZE   = 7,
    parameter int PID_W       = $clog2(NUM_PLAYERS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_game_start,
    input  logic [NUM_PLAYERS-1:0]   i_draw_req,
    input  logic [2*NUM_PLAYERS-1:0] i_draw_cnt,
    input  logic                     i_insert_req,
    input  logic [5:0]               i_insert_card,
    output logic                     o_deck_start,
    output logic                     o_deck_insert,
    output logic [2:0]               o_deck_draw,
    output logic [5:0]               o_deck_prev_card,
    input  logic                     i_deck_done,
    input  logic                     i_deck_drawn,
    input  logic [5:0]               i_deck_card,
    output logic                     o_card_valid,
    output logic [5:0]               o_card,
    output logic [PID_W-1:0]         o_card_pid,
    output logic                     o_top_valid,
    output logic [NUM_PLAYERS-1:0]   o_draw_ack,
    output logic                     o_insert_ack,
    output logic                     o_ready
);

    localparam int DEAL_TOTAL = NUM_PLAYERS * HAND_SIZE;
    localparam int DEAL_W     = $clog2(DEAL_TOTAL + 1);

    sched_state_t           r_state;
    logic                   r_settle;     // skip the cycle right after a start/insert strobe
    logic                   r_got;        // single-card handshake already saw its drawn pulse
    logic [PID_W-1:0]       r_pid;
    logic [PID_W-1:0]       r_rr_ptr;
    logic [DEAL_W-1:0]      r_deal_cnt;
    logic [1:0]             r_cnt_code;
    logic [2:0]             r_expected;
    logic [2:0]             r_delivered;

    logic                   r_deck_start;
    logic                   r_deck_insert;
    logic [2:0]             r_deck_draw;
    card_t                  r_prev_card;
    logic                   r_card_valid;
    card_t                  r_card;
    logic [PID_W-1:0]       r_card_pid;
    logic                   r_top_valid;
    logic [NUM_PLAYERS-1:0] r_draw_ack;
    logic                   r_insert_ack;
    logic                   r_ready;

    logic [PID_W-1:0]       w_grant;
    logic                   w_grant_valid;
    logic [1:0]             w_grant_code;
    logic [PID_W-1:0]       w_pid_next;

    rr_arbiter #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .PID_W       (PID_W)
    ) u_rr_arbiter (
        .i_req   (i_draw_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_grant_valid)
    );

    assign w_grant_code = i_draw_cnt[{w_grant, 1'b0} +: 2];
    assign w_pid_next   = (r_pid == PID_W'(NUM_PLAYERS - 1)) ? '0 : r_pid + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_settle      <= 1'b0;
            r_got         <= 1'b0;
            r_pid         <= '0;
            r_rr_ptr      <= '0;
            r_deal_cnt    <= '0;
            r_cnt_code    <= '0;
            r_expected    <= '0;
            r_delivered   <= '0;
            r_deck_start  <= 1'b0;
            r_deck_insert <= 1'b0;
            r_deck_draw   <= DRAW_NONE;
            r_prev_card   <= '0;
            r_card_valid  <= 1'b0;
            r_card        <= '0;
            r_card_pid    <= '0;
            r_top_valid   <= 1'b0;
            r_draw_ack    <= '0;
            r_insert_ack  <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            // Strobes and delivery pulses last exactly one cycle
            r_deck_start  <= 1'b0;
            r_deck_insert <= 1'b0;
            r_deck_draw   <= DRAW_NONE;
            r_card_valid  <= 1'b0;
            r_top_valid   <= 1'b0;
            r_draw_ack    <= '0;
            r_insert_ack  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_game_start) begin
                        r_deck_start <= 1'b1;
                        r_settle     <= 1'b1;
                        r_state      <= S_SHUFFLE;
                    end
                end

                // The deck may still report done while it samples the start
                // strobe, so one cycle is skipped before trusting done.
                S_SHUFFLE: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (i_deck_done) begin
                        r_deal_cnt <= '0;
                        r_pid      <= '0;
                        r_state    <= S_DEAL_REQ;
                    end
                end

                S_DEAL_REQ: begin
                    if (i_deck_done) begin
                        r_deck_draw <= DRAW_1;
                        r_got       <= 1'b0;
                        r_state     <= S_DEAL_WAIT;
                    end
                end

                // Done is only trusted after the drawn pulse, so a stale
                // done level from before the strobe cannot end the handshake.
                S_DEAL_WAIT: begin
                    if (i_deck_drawn && !r_got) begin
                        r_got        <= 1'b1;
                        r_card_valid <= 1'b1;
                        r_card       <= i_deck_card;
                        r_card_pid   <= r_pid;
                        r_pid        <= w_pid_next;
                        r_deal_cnt   <= r_deal_cnt + 1'b1;
                    end else if (r_got && i_deck_done) begin
                        r_state <= (r_deal_cnt == DEAL_W'(DEAL_TOTAL)) ? S_FLIP : S_DEAL_REQ;
                    end
                end

                S_FLIP: begin
                    if (i_deck_done) begin
                        r_deck_draw <= DRAW_1;
                        r_got       <= 1'b0;
                        r_state     <= S_FLIP_WAIT;
                    end
                end

                S_FLIP_WAIT: begin
                    if (i_deck_drawn && !r_got) begin
                        r_got       <= 1'b1;
                        r_top_valid <= 1'b1;
                        r_card      <= i_deck_card;
                    end else if (r_got && i_deck_done) begin
                        r_ready <= 1'b1;
                        r_state <= S_READY;
                    end
                end

                S_READY: begin
                    if (i_deck_done) begin
                        if (i_insert_req) begin
                            // Latched here and held until the next insert
                            r_prev_card   <= i_insert_card;
                            r_deck_insert <= 1'b1;
                            r_settle      <= 1'b1;
                            r_ready       <= 1'b0;
                            r_state       <= S_INSERT;
                        end else if (w_grant_valid) begin
                            r_pid      <= w_grant;
                            r_cnt_code <= w_grant_code;
                            r_ready    <= 1'b0;
                            r_state    <= S_DRAW_REQ;
                        end
                    end
                end

                // The one-hot draw code is numerically the card count
                S_DRAW_REQ: begin
                    r_deck_draw <= cnt_to_onehot(r_cnt_code);
                    r_expected  <= cnt_to_onehot(r_cnt_code);
                    r_delivered <= '0;
                    r_state     <= S_DRAW_WAIT;
                end

                S_DRAW_WAIT: begin
                    // Drawn pulses past the expected count are dropped
                    if (i_deck_drawn && (r_delivered != r_expected)) begin
                        r_card_valid <= 1'b1;
                        r_card       <= i_deck_card;
                        r_card_pid   <= r_pid;
                        r_delivered  <= r_delivered + 1'b1;
                    end
                    if ((r_delivered == r_expected) && i_deck_done) begin
                        r_draw_ack <= NUM_PLAYERS'(1) << r_pid;
                        r_rr_ptr   <= w_pid_next;
                        r_ready    <= 1'b1;
                        r_state    <= S_READY;
                    end
                end

                S_INSERT: begin
                    if (r_settle) begin
                        r_settle <= 1'b0;
                    end else if (i_deck_done) begin
                        r_insert_ack <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= S_READY;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_deck_start     = r_deck_start;
    assign o_deck_insert    = r_deck_insert;
    assign o_deck_draw      = r_deck_draw;
    assign o_deck_prev_card = r_prev_card;
    assign o_card_valid     = r_card_valid;
    assign o_card           = r_card;
    assign o_card_pid       = r_card_pid;
    assign o_top_valid      = r_top_valid;
    assign o_draw_ack       = r_draw_ack;
    assign o_insert_ack     = r_insert_ack;
    assign o_ready          = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_deck_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deck_scheduler
//  Description : Self-checking bench for deck_scheduler. A behavioural deck
//                answers strobes with random latencies; a transaction-level
//                model predicts the ordered list of visible events (strobes,
//                deliveries, acks) and every observed event is compared
//                against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deck_scheduler;

    localparam int NP = 4;
    localparam int HS = 7;
    localparam int PW = 2;

    localparam int EV_START = 1;
    localparam int EV_DRAW  = 2;
    localparam int EV_CARD  = 3;
    localparam int EV_TOP   = 4;
    localparam int EV_ACK   = 5;
    localparam int EV_INS   = 6;
    localparam int EV_IACK  = 7;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_game_start;
    logic [NP-1:0]     i_draw_req;
    logic [2*NP-1:0]   i_draw_cnt;
    logic              i_insert_req;
    logic [5:0]        i_insert_card;
    logic              o_deck_start;
    logic              o_deck_insert;
    logic [2:0]        o_deck_draw;
    logic [5:0]        o_deck_prev_card;
    logic              i_deck_done;
    logic              i_deck_drawn;
    logic [5:0]        i_deck_card;
    logic              o_card_valid;
    logic [5:0]        o_card;
    logic [PW-1:0]     o_card_pid;
    logic              o_top_valid;
    logic [NP-1:0]     o_draw_ack;
    logic              o_insert_ack;
    logic              o_ready;

    deck_scheduler #(
        .NUM_PLAYERS (NP),
        .HAND_SIZE   (HS)
    ) u_dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_game_start     (i_game_start),
        .i_draw_req       (i_draw_req),
        .i_draw_cnt       (i_draw_cnt),
        .i_insert_req     (i_insert_req),
        .i_insert_card    (i_insert_card),
        .o_deck_start     (o_deck_start),
        .o_deck_insert    (o_deck_insert),
        .o_deck_draw      (o_deck_draw),
        .o_deck_prev_card (o_deck_prev_card),
        .i_deck_done      (i_deck_done),
        .i_deck_drawn     (i_deck_drawn),
        .i_deck_card      (i_deck_card),
        .o_card_valid     (o_card_valid),
        .o_card           (o_card),
        .o_card_pid       (o_card_pid),
        .o_top_valid      (o_top_valid),
        .o_draw_ack       (o_draw_ack),
        .o_insert_ack     (o_insert_ack),
        .o_ready          (o_ready)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mk(input int kind, input int pid, input int data);
        return {4'(kind), 4'(pid), 8'(data)};
    endfunction

    // ---------------- model state ----------------
    logic [15:0] exp_q[$];
    int          extra_q[$];   // extra drawn pulses per draw, in service order
    int          m_pos = 0;    // next card index out of the deck
    int          m_ptr = 0;    // round-robin pointer
    int          g_stall = -1; // forced done delay after last card (-1: random)
    int          n_cards = 0;

    // ---------------- behavioural deck ----------------
    int          dk_phase = 0;
    int          dk_left, dk_gap, dk_wait, dk_stall;
    int          dk_next = 0;
    int          dk_rise = 0;
    logic        dk_is_ins = 1'b0;
    logic [5:0]  dk_ins_card;

    initial begin
        i_deck_done  = 1'b1;
        i_deck_drawn = 1'b0;
        i_deck_card  = '0;
        forever begin
            @(negedge i_clk);
            i_deck_drawn = 1'b0;
            if (i_rst) begin
                dk_phase    = 0;
                dk_next     = 0;
                i_deck_done = 1'b1;
                extra_q.delete();
            end else begin
                case (dk_phase)
                    0: begin
                        if (o_deck_start) begin
                            i_deck_done = 1'b0;
                            dk_is_ins   = 1'b0;
                            dk_wait     = $urandom_range(1, 4);
                            dk_phase    = 2;
                        end else if (o_deck_draw != 3'b000) begin
                            i_deck_done = 1'b0;
                            dk_is_ins   = 1'b0;
                            dk_left     = o_deck_draw[0] ? 1 : (o_deck_draw[1] ? 2 : 4);
                            if (extra_q.size() > 0) dk_left += extra_q.pop_front();
                            dk_gap      = $urandom_range(0, 2);
                            dk_stall    = (g_stall >= 0) ? g_stall : $urandom_range(0, 3);
                            dk_phase    = 1;
                        end else if (o_deck_insert) begin
                            i_deck_done = 1'b0;
                            dk_is_ins   = 1'b1;
                            dk_ins_card = o_deck_prev_card;
                            dk_wait     = $urandom_range(1, 4);
                            dk_phase    = 2;
                        end
                    end
                    1: begin
                        if (dk_gap > 0) begin
                            dk_gap--;
                        end else begin
                            i_deck_drawn = 1'b1;
                            i_deck_card  = 6'(dk_next);
                            dk_next++;
                            dk_left--;
                            dk_gap = $urandom_range(0, 2);
                            if (dk_left == 0) begin
                                dk_wait  = dk_stall;
                                dk_phase = 2;
                            end
                        end
                    end
                    default: begin
                        if (dk_wait > 0) begin
                            dk_wait--;
                        end else begin
                            if (dk_is_ins) check("prev_card_hold", 32'(o_deck_prev_card), 32'(dk_ins_card));
                            i_deck_done = 1'b1;
                            dk_rise     = cyc;
                            dk_phase    = 0;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- event monitor ----------------
    task automatic observe(input logic [15:0] ev);
        if (exp_q.size() == 0) check("event_unexpected", 32'(ev), 32'h0);
        else                   check("event", 32'(ev), 32'(exp_q.pop_front()));
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_deck_start)          observe(mk(EV_START, 0, 0));
                if (o_deck_draw != 3'b000) observe(mk(EV_DRAW, 0, int'(o_deck_draw)));
                if (o_deck_insert)         observe(mk(EV_INS, 0, int'(o_deck_prev_card)));
                if (o_card_valid) begin
                    observe(mk(EV_CARD, int'(o_card_pid), int'(o_card)));
                    n_cards++;
                end
                if (o_top_valid)           observe(mk(EV_TOP, 0, int'(o_card)));
                if (o_draw_ack != '0) begin
                    observe(mk(EV_ACK, 0, int'(o_draw_ack)));
                    check("ack_latency", 32'(cyc - dk_rise), 32'd1);
                end
                if (o_insert_ack)          observe(mk(EV_IACK, 0, 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        check("reset_outputs",
              {5'b0, o_deck_start, o_deck_insert, o_deck_draw, o_deck_prev_card,
               o_card_valid, o_card, o_card_pid, o_top_valid, o_draw_ack,
               o_insert_ack, o_ready}, 32'h0);
        exp_q.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst        = 1'b0;
        i_draw_req   = '0;
        i_insert_req = 1'b0;
        m_pos        = 0;
        m_ptr        = 0;
    endtask

    task automatic start_game();
        exp_q.push_back(mk(EV_START, 0, 0));
        for (int k = 0; k < NP * HS; k++) begin
            exp_q.push_back(mk(EV_DRAW, 0, 1));
            exp_q.push_back(mk(EV_CARD, k % NP, k));
        end
        exp_q.push_back(mk(EV_DRAW, 0, 1));
        exp_q.push_back(mk(EV_TOP, 0, NP * HS));
        m_pos   = NP * HS + 1;
        m_ptr   = 0;
        n_cards = 0;
        i_game_start = 1'b1;
        @(negedge i_clk);
        i_game_start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int t = 0; t < 3000 && !o_ready; t++) @(negedge i_clk);
        check(tag, 32'(o_ready), 32'd1);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_batch(input logic ins, input logic [5:0] icard, input logic [NP-1:0] req,
                             input logic [2*NP-1:0] cnt, input int stall);
        int p, code, c, e, base;
        g_stall = stall;
        if (ins) begin
            exp_q.push_back(mk(EV_INS, 0, int'(icard)));
            exp_q.push_back(mk(EV_IACK, 0, 0));
        end
        // Each served player moves the pointer just past itself, so the
        // service order is one wrapping sweep starting at the pointer.
        base = m_ptr;
        for (int i = 0; i < NP; i++) begin
            p = (base + i) % NP;
            if (req[p]) begin
                code = int'(cnt[2*p +: 2]);
                c    = (code == 3) ? 1 : (1 << code);
                exp_q.push_back(mk(EV_DRAW, 0, c));
                for (int j = 0; j < c; j++) exp_q.push_back(mk(EV_CARD, p, (m_pos + j) % 64));
                e = $urandom_range(0, 1);
                extra_q.push_back(e);
                m_pos = m_pos + c + e;
                exp_q.push_back(mk(EV_ACK, 0, 1 << p));
                m_ptr = (p + 1) % NP;
            end
        end
        i_insert_card = icard;
        i_insert_req  = ins;
        i_draw_cnt    = cnt;
        i_draw_req    = req;
        for (int t = 0; t < 800 && (i_draw_req != '0 || i_insert_req); t++) begin
            @(negedge i_clk);
            if (o_draw_ack != '0) i_draw_req = i_draw_req & ~o_draw_ack;
            if (o_insert_ack)     i_insert_req = 1'b0;
            if (o_deck_insert)    i_insert_card = 6'($urandom);
        end
        check("batch_all_acked", {27'b0, i_insert_req, i_draw_req}, 32'h0);
        repeat (2) @(negedge i_clk);
        check("batch_pending", 32'(exp_q.size()), 32'd0);
        check("batch_ready", 32'(o_ready), 32'd1);
        g_stall = -1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        i_rst         = 1'b0;
        i_game_start  = 1'b0;
        i_draw_req    = '0;
        i_draw_cnt    = '0;
        i_insert_req  = 1'b0;
        i_insert_card = '0;
        @(negedge i_clk);
        do_reset();

        // Full deal and flip
        start_game();
        wait_ready("deal_ready");

        // Round robin: move pointer to 2, then players 3 and 1 requesting
        run_batch(1'b0, 6'h00, 4'b0010, 8'h00, -1);
        run_batch(1'b0, 6'h00, 4'b1010, 8'h00, -1);

        // Draw four for player 0
        run_batch(1'b0, 6'h00, 4'b0001, 8'b0000_0010, -1);

        // Insert beats a simultaneous draw
        run_batch(1'b1, 6'h15, 4'b0001, 8'h00, -1);

        // Long done stall after the last card
        run_batch(1'b0, 6'h00, 4'b0100, 8'b0001_0000, 20);

        // Game start while ready is ignored
        i_game_start = 1'b1;
        @(negedge i_clk);
        i_game_start = 1'b0;
        repeat (5) @(negedge i_clk);
        check("start_ignored_ready", 32'(o_ready), 32'd1);

        // Randomized batches, including reserved count code 3
        for (int b = 0; b < 15; b++) begin
            run_batch(1'($urandom), 6'($urandom), NP'($urandom), (2*NP)'($urandom), -1);
        end

        // Reset in the middle of the deal, then redeal from player 0
        do_reset();
        start_game();
        for (int t = 0; t < 2000 && n_cards < 10; t++) @(negedge i_clk);
        check("mid_deal_cards", 32'(n_cards >= 10), 32'd1);
        do_reset();
        start_game();
        wait_ready("redeal_ready");
        run_batch(1'($urandom), 6'($urandom), 4'b1111, (2*NP)'($urandom), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
